// File: rtl/sha256_hash_state.sv
// sha256_hash_state: holds the SHA-256 chaining value H0..H7 for one message.
// It seeds the compression core with the current H, absorbs the core's final
// working variables with per-word mod-2^32 addition, and presents the digest
// after the last block on a valid/ready port.
// Optional build macro SHA224_MODE_EN adds the sha224_sel input, which selects
// the SHA-224 IV and zeroes the low digest word.
module sha256_hash_state #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_start,
`ifdef SHA224_MODE_EN
  input  logic             sha224_sel,
`endif
  output logic             seed_valid,
  input  logic             seed_ready,
  output logic [255:0]     seed_data,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  input  logic [255:0]     rnd_data,
  input  logic             rnd_last,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [255:0]     dig_data,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             busy
);

  localparam logic [255:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WAIT,
    S_ADD,
    S_OUT
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [255:0]     h_q;
  logic [255:0]     rnd_q;
  logic             last_q;
  logic [255:0]     iv;

`ifdef SHA224_MODE_EN
  localparam logic [255:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  logic mode224_q;

  // IV choice follows sha224_sel, which only matters when msg_start loads it.
  assign iv       = sha224_sel ? IV_224 : IV_256;
  assign dig_data = mode224_q ? {h_q[255:32], 32'h0} : h_q;

  // Remember which digest variant this message uses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode224_q <= 1'b0;
    end else if (msg_start) begin
      mode224_q <= sha224_sel;
    end
  end
`else
  assign iv       = IV_256;
  assign dig_data = h_q;
`endif

  assign seed_data = h_q;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; msg_start overrides any handshake in every state.
  // NOTE: the default assignment first keeps this purely combinational (no latch).
  always_comb begin
    state_nxt = state_q;
    if (msg_start) begin
      state_nxt = S_SEED;
    end else begin
      case (state_q)
        S_IDLE: state_nxt = S_IDLE;
        S_SEED: if (seed_ready) state_nxt = S_WAIT;
        S_WAIT: if (rnd_valid)  state_nxt = S_ADD;
        S_ADD:  state_nxt = last_q ? S_OUT : S_SEED;
        S_OUT:  if (dig_ready)  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the current state.
  always_comb begin
    seed_valid = (state_q == S_SEED);
    rnd_ready  = (state_q == S_WAIT);
    dig_valid  = (state_q == S_OUT);
    busy       = (state_q != S_IDLE);
  end

  // Datapath: IV load, result capture, per-word absorb and block counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= '0;
      rnd_q   <= '0;
      last_q  <= 1'b0;
      blk_cnt <= '0;
    end else if (msg_start) begin
      h_q     <= iv;
      blk_cnt <= '0;
    end else if (state_q == S_WAIT && rnd_valid) begin
      rnd_q  <= rnd_data;
      last_q <= rnd_last;
    end else if (state_q == S_ADD) begin
      // Each 32-bit lane wraps on its own; no carry crosses word boundaries.
      for (int i = 0; i < 8; i++) begin
        h_q[i*32 +: 32] <= h_q[i*32 +: 32] + rnd_q[i*32 +: 32];
      end
      if (blk_cnt != '1) begin
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
    end
  end

endmodule
